cctl_spi_ctrl: RTL and testbench
================================

Name: cctl_spi_ctrl

Overview:
- Hardware SPI master for the RTC/serial-device port in the cartridge CCTL window ($D5B8..$D5BF, cart_a[7:3] = 5'b10111).
- Replaces 6502 bit-banging of sck/mosi/miso/sel_n: the CPU writes a byte and the block shifts it out in SPI mode 0 while capturing the reply.
- Sits beside the SDX banking logic in the top level, which muxes rd_data onto cart_d when rd_en is high and phi2 is high.

Parameters:
- CLK_DIV, 2: phi2 cycles per SCK half-period (≥1).
- BASE_A, 5'b10111: cart_a[7:3] match for the register window.

Ports:
- phi2  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cctl_n  input  1  cartridge control select, active low.
- r_w  input  1  bus direction, 1 = read.
- cart_a  input  8  address low byte; [7:3] window match, [2:0] register select.
- wr_data  input  8  cart_d as driven by the CPU.
- rd_data  output  8  register read value (combinational).
- rd_en  output  1  hit & r_w; top level drives cart_d.
- sck  output  1  SPI clock, idle low.
- mosi  output  1  SPI data out, MSB first.
- miso  input  1  SPI data in.
- sel_n  output  1  device chip select, active low.
- busy  output  1  transfer in progress.

Behaviour:
- hit = ~cctl_n & (cart_a[7:3] == BASE_A). wr = hit & ~r_w, sampled on posedge phi2. One bus cycle is one phi2 cycle, so one write produces one event.
- Register map on cart_a[2:0] (other offsets read 8'h00, writes ignored):
  - 0 DATA, write: load tx byte and start a transfer. Read: last completed rx byte.
  - 1 CTRL, write: bit0 = cs (sel_n = ~cs), bit2 = 1 clears overrun. Read: {busy, overrun, 5'b0, cs}.
- Reset values: sck 0, mosi 0, sel_n 1, busy 0, rx 8'h00, overrun 0, cs 0, state IDLE.
- FSM states: IDLE, LO, HI. A half-period counter runs from CLK_DIV-1 down to 0. bit_cnt runs 0..7.
  - IDLE: on a DATA write, shift <= wr_data, mosi <= wr_data[7], busy <= 1, bit_cnt <= 0, counter reloads, go to LO.
  - LO, counter = 0: sck <= 1, shift[0] captures miso (shift left by one, miso in), go to HI with reload.
  - HI, counter = 0: sck <= 0.
    - If bit_cnt = 7: rx <= shift, busy <= 0, go to IDLE. mosi holds its last value.
    - Otherwise: bit_cnt++, mosi <= next MSB, go to LO.
- Latency: busy is high for exactly 16*CLK_DIV cycles, starting the cycle after the write edge. rx is valid the same edge busy falls.
- A DATA write while busy is ignored and sets overrun. The in-flight transfer is unaffected.
- A CTRL write while busy: only the overrun-clear bit takes effect. The cs bit is ignored, so sel_n cannot change mid-byte.
- A DATA read while busy returns the previous rx byte.
- Reset mid-transfer aborts on that edge: all outputs return to reset values and no rx update occurs.
- sel_n is never toggled automatically; software frames multi-byte transactions with CTRL.cs.

Decomposition:
- Shared package holds:
  - register offsets REG_DATA = 3'd0, REG_CTRL = 3'd1;
  - CTRL bit positions CS = 0, OVR_CLR = 2;
  - STATUS bit positions BUSY = 7, OVR = 6;
  - FSM state enum {IDLE, LO, HI}.
- One sub-module, spi_shift_engine, holds the FSM, divider, shift register and bit counter. Its interface is start / tx_byte / rx_byte / busy.
- Register decode, cs and overrun stay in cctl_spi_ctrl.

Test Plan:
- Reset, then CTRL write 8'h01 → sel_n goes 0 on the next edge. Reading CTRL returns 8'h01.
- CLK_DIV=2, DATA write 8'hA5 with miso looped to mosi → mosi sequence 1,0,1,0,0,1,0,1 on rising sck. busy is high for 32 cycles. DATA read then returns 8'hA5.
- DATA write 8'h3C with miso tied 1 → rx 8'hFF. 8 sck rising edges, sck ends low.
- DATA write 8'h55 issued 5 cycles into a busy transfer → in-flight transfer unaffected. STATUS reads 8'hC1 (busy, overrun, cs). CTRL write 8'h05 clears overrun, and STATUS reads 8'h01 after completion.
- CTRL write 8'h00 during busy → sel_n stays 0. reset asserted at cycle 10 of a transfer → next edge gives sck 0, sel_n 1, busy 0, rx 8'h00.
- Access with cctl_n=1, or cart_a[7:3] ≠ BASE_A → no state change and rd_en stays 0.

Source files
------------

// File: rtl/cctl_spi_ctrl_pkg.sv
// rtl/cctl_spi_ctrl_pkg.sv - shared register map, bit positions and FSM states for the CCTL SPI master
package cctl_spi_ctrl_pkg;

  localparam logic [2:0] REG_DATA = 3'd0;
  localparam logic [2:0] REG_CTRL = 3'd1;

  localparam int CTRL_CS      = 0;
  localparam int CTRL_OVR_CLR = 2;

  localparam int STAT_BUSY = 7;
  localparam int STAT_OVR  = 6;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI
  } spi_state_e;

endpackage

// File: rtl/cctl_spi_ctrl_spi_shift_engine.sv
// rtl/cctl_spi_ctrl_spi_shift_engine.sv - mode-0 SPI byte shifter with SCK divider
module spi_shift_engine
  import cctl_spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       phi2,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       sck,
  output logic       mosi
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

  spi_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = tx_byte;
          mosi_d  = tx_byte[7];
          bit_d   = 3'd0;
          cnt_d   = LOAD;
          state_d = LO;
        end
      end
      LO: begin
        if (cnt_q == '0) begin
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], miso};
          cnt_d   = LOAD;
          state_d = HI;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HI: begin
        if (cnt_q == '0) begin
          sck_d = 1'b0;
          cnt_d = LOAD;
          if (bit_q == 3'd7) begin
            rx_d    = shift_q;
            state_d = IDLE;
          end else begin
            // shift_q already holds the captured bits, so its MSB is the next tx bit
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
            state_d = LO;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      rx_q    <= 8'h00;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  assign rx_byte = rx_q;
  assign busy    = (state_q != IDLE);
  assign sck     = sck_q;
  assign mosi    = mosi_q;

endmodule

// File: rtl/cctl_spi_ctrl.sv
// rtl/cctl_spi_ctrl.sv - CCTL-window register front end for the RTC/serial SPI master
module cctl_spi_ctrl
  import cctl_spi_ctrl_pkg::*;
#(
  parameter int         CLK_DIV = 2,
  parameter logic [4:0] BASE_A  = 5'b10111
) (
  input  logic       phi2,
  input  logic       reset,
  input  logic       cctl_n,
  input  logic       r_w,
  input  logic [7:0] cart_a,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rd_en,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       sel_n,
  output logic       busy
);

  logic       hit, wr, data_wr, ctrl_wr, start;
  logic       eng_busy;
  logic [7:0] rx_byte;
  logic [7:0] status;
  logic       cs_q, cs_d;
  logic       ovr_q, ovr_d;

  assign hit     = ~cctl_n & (cart_a[7:3] == BASE_A);
  assign wr      = hit & ~r_w;
  assign data_wr = wr & (cart_a[2:0] == REG_DATA);
  assign ctrl_wr = wr & (cart_a[2:0] == REG_CTRL);
  assign start   = data_wr & ~eng_busy;

  // cs is frozen while a byte is on the wire so sel_n cannot glitch mid-transfer
  always_comb begin
    cs_d  = cs_q;
    ovr_d = ovr_q;
    if (data_wr && eng_busy) ovr_d = 1'b1;
    if (ctrl_wr) begin
      if (wr_data[CTRL_OVR_CLR]) ovr_d = 1'b0;
      if (!eng_busy) cs_d = wr_data[CTRL_CS];
    end
  end

  always_ff @(posedge phi2) begin
    if (reset) begin
      cs_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      cs_q  <= cs_d;
      ovr_q <= ovr_d;
    end
  end

  always_comb begin
    status            = 8'h00;
    status[STAT_BUSY] = eng_busy;
    status[STAT_OVR]  = ovr_q;
    status[CTRL_CS]   = cs_q;
    rd_data           = 8'h00;
    case (cart_a[2:0])
      REG_DATA: rd_data = rx_byte;
      REG_CTRL: rd_data = status;
      default:  rd_data = 8'h00;
    endcase
  end

  spi_shift_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .phi2   (phi2),
    .reset  (reset),
    .start  (start),
    .tx_byte(wr_data),
    .miso   (miso),
    .rx_byte(rx_byte),
    .busy   (eng_busy),
    .sck    (sck),
    .mosi   (mosi)
  );

  assign rd_en = hit & r_w;
  assign sel_n = ~cs_q;
  assign busy  = eng_busy;

endmodule

// File: tb/tb_cctl_spi_ctrl.sv
// tb/tb_cctl_spi_ctrl.sv - self-checking bench for cctl_spi_ctrl with a transfer-level reference model
module tb_cctl_spi_ctrl;

  localparam int D = 2;
  localparam logic [4:0] BASE = 5'b10111;

  logic       phi2 = 1'b0;
  logic       reset, cctl_n, r_w, miso_r, loop_en;
  logic [7:0] cart_a, wr_data;
  logic [7:0] rd_data;
  logic       rd_en, sck, mosi, sel_n, busy;
  wire        miso = loop_en ? mosi : miso_r;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_en = 0;

  // reference model: transfer described by elapsed edges since start
  bit       m_busy, m_cs, m_ovr, m_sck, m_mosi;
  int       m_e;
  logic [7:0] m_tx, m_rx, m_cap;

  cctl_spi_ctrl #(.CLK_DIV(D), .BASE_A(BASE)) dut (
    .phi2(phi2), .reset(reset), .cctl_n(cctl_n), .r_w(r_w), .cart_a(cart_a),
    .wr_data(wr_data), .rd_data(rd_data), .rd_en(rd_en), .sck(sck), .mosi(mosi),
    .miso(miso), .sel_n(sel_n), .busy(busy)
  );

  always #5 phi2 = ~phi2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge phi2) begin
    bit ob;
    bit hit;
    if (reset) begin
      m_busy = 0; m_cs = 0; m_ovr = 0; m_sck = 0; m_mosi = 0;
      m_e = 0; m_tx = 8'h00; m_rx = 8'h00; m_cap = 8'h00;
    end else begin
      ob = m_busy;
      if (ob) begin
        m_e++;
        if (m_e % (2*D) == D) m_cap[7 - m_e/(2*D)] = miso;
        if (m_e == 16*D) begin
          m_busy = 0;
          m_rx   = m_cap;
        end
      end
      hit = !cctl_n && cart_a[7:3] == BASE;
      if (hit && !r_w) begin
        if (cart_a[2:0] == 3'd0) begin
          if (ob) m_ovr = 1;
          else begin
            m_tx = wr_data; m_busy = 1; m_e = 0;
          end
        end else if (cart_a[2:0] == 3'd1) begin
          if (wr_data[2]) m_ovr = 0;
          if (!ob) m_cs = wr_data[0];
        end
      end
      m_sck = m_busy && (m_e % (2*D) >= D);
      if (m_busy) m_mosi = m_tx[7 - m_e/(2*D)];
    end
  end

  always @(negedge phi2) begin
    bit exp_rd;
    logic [7:0] exp_d;
    if (chk_en) begin
      exp_rd = !cctl_n && cart_a[7:3] == BASE && r_w;
      chk("sck", sck, m_sck);
      chk("mosi", mosi, m_mosi);
      chk("sel_n", sel_n, !m_cs);
      chk("busy", busy, m_busy);
      chk("rd_en", rd_en, exp_rd);
      if (exp_rd) begin
        case (cart_a[2:0])
          3'd0:    exp_d = m_rx;
          3'd1:    exp_d = {m_busy, m_ovr, 5'b0, m_cs};
          default: exp_d = 8'h00;
        endcase
        chk("rd_data", rd_data, exp_d);
      end
    end
  end

  task automatic cyc();
    @(posedge phi2);
    #1;
  endtask

  task automatic bus_idle();
    cctl_n = 1'b1; r_w = 1'b1;
  endtask

  task automatic bus_wr(input bit n_cctl, input logic [7:0] a, input logic [7:0] d);
    cctl_n = n_cctl; r_w = 1'b0; cart_a = a; wr_data = d;
    cyc();
    bus_idle();
  endtask

  task automatic bus_rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
    cctl_n = 1'b0; r_w = 1'b1; cart_a = a;
    @(negedge phi2);
    chk(nm, rd_data, exp);
    cyc();
    bus_idle();
  endtask

  task automatic measure(output int bcyc, output int rises, output logic [7:0] seq);
    logic prev;
    prev = 1'b0; bcyc = 0; rises = 0; seq = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge phi2);
      if (!busy) break;
      bcyc++;
      if (sck && !prev) begin
        seq = {seq[6:0], mosi};
        rises++;
      end
      prev = sck;
    end
    cyc();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    int bc, rs;
    logic [7:0] seq;
    reset = 1; cctl_n = 1; r_w = 1; cart_a = 8'h00; wr_data = 8'h00;
    miso_r = 0; loop_en = 0;
    repeat (3) cyc();
    chk_en = 1;
    chk("rst_sck", sck, 1'b0);
    chk("rst_sel_n", sel_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    reset = 0;
    bus_rd("rst_data", 8'hB8, 8'h00);
    bus_rd("rst_ctrl", 8'hB9, 8'h00);

    bus_wr(0, 8'hB9, 8'h01);
    chk("cs_sel_n", sel_n, 1'b0);
    bus_rd("cs_ctrl", 8'hB9, 8'h01);

    loop_en = 1;
    bus_wr(0, 8'hB8, 8'hA5);
    measure(bc, rs, seq);
    loop_en = 0;
    chk("a5_busy_cycles", bc, 32);
    chk("a5_rises", rs, 8);
    chk("a5_mosi_seq", seq, 8'hA5);
    bus_rd("a5_rx", 8'hB8, 8'hA5);

    miso_r = 1;
    bus_wr(0, 8'hB8, 8'h3C);
    measure(bc, rs, seq);
    chk("3c_rises", rs, 8);
    chk("3c_mosi_seq", seq, 8'h3C);
    chk("3c_sck_end", sck, 1'b0);
    bus_rd("3c_rx", 8'hB8, 8'hFF);

    miso_r = 0;
    bus_wr(0, 8'hB8, 8'h12);
    repeat (4) cyc();
    bus_wr(0, 8'hB8, 8'h55);
    bus_rd("ovr_status", 8'hB9, 8'hC1);
    bus_wr(0, 8'hB9, 8'h05);
    wait_idle("ovr_done");
    bus_rd("ovr_clr_status", 8'hB9, 8'h01);
    bus_rd("ovr_rx", 8'hB8, 8'h00);

    bus_wr(0, 8'hB8, 8'h77);
    bus_wr(0, 8'hB9, 8'h00);
    chk("cs_frozen", sel_n, 1'b0);
    repeat (8) cyc();
    reset = 1;
    cyc();
    reset = 0;
    chk("abort_sck", sck, 1'b0);
    chk("abort_sel_n", sel_n, 1'b1);
    chk("abort_busy", busy, 1'b0);
    bus_rd("abort_rx", 8'hB8, 8'h00);

    bus_wr(1, 8'hB9, 8'h01);
    chk("nocctl_sel_n", sel_n, 1'b1);
    bus_wr(0, 8'h99, 8'h01);
    chk("miss_sel_n", sel_n, 1'b1);
    bus_wr(0, 8'hB0, 8'h5A);
    chk("miss_busy", busy, 1'b0);
    cctl_n = 0; r_w = 1; cart_a = 8'h99;
    @(negedge phi2);
    chk("miss_rd_en", rd_en, 1'b0);
    cyc();
    bus_idle();

    for (int i = 0; i < 4000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      cctl_n  = ($urandom_range(0, 9) > 2);
      r_w     = $urandom_range(0, 1);
      cart_a  = ($urandom_range(0, 9) < 8) ? {BASE, 3'($urandom_range(0, 3))} : 8'($urandom);
      wr_data = 8'($urandom);
      miso_r  = $urandom_range(0, 1);
      loop_en = ($urandom_range(0, 7) == 0);
      cyc();
    end
    reset = 0; loop_en = 0;
    bus_idle();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
